// File: rtl/rfarb_pkg.sv
// Shared defaults and pipeline record for the register-file arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rfarb_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int DW_DEF       = 16;
    localparam int AW_DEF       = 3;
    localparam int LOCK_MAX_DEF = 4;

    // Requester index width; resp_id is always this wide (up to 8 requesters)
    localparam int ID_W = 3;

    // Valid bit plus owner id carried alongside an operation through I and C stages
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } stage_t;

endpackage

// File: rtl/regfile_arbiter_rr_grant.sv
// Rotating-priority one-hot grant: first pending requester at or after ptr wins.
// Latency: purely combinational.
// Backpressure: none; gnt is all zero when no vld bit is set.
module rr_grant #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  vld,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    // Scan upward from ptr with wrap-around and grant the first pending requester
    always_comb begin : p_scan
        logic        found;
        logic [PW:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && vld[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register-file port; optional grant locking under RFARB_LOCK_EN.
// Latency: 2 cycles from acceptance edge to resp_valid; one operation accepted per cycle.
// Backpressure: one-hot req_ready grant to requesters; responses are never stalled.
module regfile_arbiter
    import rfarb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_aa,
    input  logic [NREQ*AW-1:0]   req_ba,
    input  logic [NREQ*AW-1:0]   req_da,
    input  logic [NREQ*DW-1:0]   req_dd,
    input  logic [NREQ-1:0]      req_lock,
    output logic [AW-1:0]        RF_AA,
    output logic [AW-1:0]        RF_BA,
    output logic [AW-1:0]        RF_DA,
    output logic [DW-1:0]        RF_DD,
    output logic                 RF_RW,
    input  logic [DW-1:0]        RF_AD,
    input  logic [DW-1:0]        RF_BD,
    output logic                 resp_valid,
    output logic [2:0]           resp_id,
    output logic [DW-1:0]        resp_ad,
    output logic [DW-1:0]        resp_bd,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] rr_gnt;
    logic [NREQ-1:0] gnt;
    logic            acc;
    logic [ID_W-1:0] win_id;

    logic [AW-1:0]   rf_aa_q, rf_aa_d;
    logic [AW-1:0]   rf_ba_q, rf_ba_d;
    logic [AW-1:0]   rf_da_q, rf_da_d;
    logic [DW-1:0]   rf_dd_q, rf_dd_d;
    logic            rf_rw_q, rf_rw_d;

    stage_t          i_stg_q, i_stg_d;
    stage_t          c_stg_q, c_stg_d;

    logic            resp_valid_q, resp_valid_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [DW-1:0]   resp_ad_q, resp_ad_d;
    logic [DW-1:0]   resp_bd_q, resp_bd_d;

    rr_grant #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_grant (
        .vld (req_valid),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

`ifdef RFARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic            lock_on_q, lock_on_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NREQ-1:0] lock_gnt;
    logic [CW-1:0]   cnt_nx;

    // Lock owner keeps the grant only while it still presents a request
    always_comb begin
        lock_gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (lock_on_q && (lock_id_q == ID_W'(i)) && req_valid[i]) begin
                lock_gnt[i] = 1'b1;
            end
        end
    end

    // A live lock overrides the rotating-priority grant
    always_comb begin
        gnt = (|lock_gnt) ? lock_gnt : rr_gnt;
    end

    // Count consecutive locked grants; the first locked request counts as one,
    // and reaching LOCK_MAX drops the lock so the next arbitration is fair
    always_comb begin
        cnt_nx     = (|lock_gnt) ? (lock_cnt_q + CW'(1)) : CW'(1);
        lock_on_d  = 1'b0;
        lock_id_d  = lock_id_q;
        lock_cnt_d = '0;
        if (acc && (|(req_lock & req_ready)) && (cnt_nx < CW'(LOCK_MAX))) begin
            lock_on_d  = 1'b1;
            lock_id_d  = win_id;
            lock_cnt_d = cnt_nx;
        end
    end

    // Lock state registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lock_on_q  <= 1'b0;
            lock_id_q  <= '0;
            lock_cnt_q <= '0;
        end else begin
            lock_on_q  <= lock_on_d;
            lock_id_q  <= lock_id_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    // Without locking the grant is the rotating-priority result; req_lock is ignored
    assign gnt = rr_gnt;

    logic unused_lock;
    assign unused_lock = (^req_lock) ^ (LOCK_MAX > 0);
`endif

    // Grant is suppressed while reset is held
    assign req_ready = gnt & {NREQ{RESET}};
    assign acc       = |req_ready;

    // Mux the winner's fields onto the register-file port and advance the pointer past it
    always_comb begin
        win_id  = '0;
        rf_aa_d = rf_aa_q;
        rf_ba_d = rf_ba_q;
        rf_da_d = rf_da_q;
        rf_dd_d = rf_dd_q;
        rf_rw_d = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                win_id  = ID_W'(i);
                rf_aa_d = req_aa[i*AW +: AW];
                rf_ba_d = req_ba[i*AW +: AW];
                rf_da_d = req_da[i*AW +: AW];
                rf_dd_d = req_dd[i*DW +: DW];
                rf_rw_d = req_we[i];
            end
        end
        ptr_d = ptr_q;
        if (acc) begin
            ptr_d = (win_id == ID_W'(NREQ - 1)) ? '0 : PW'(win_id + ID_W'(1));
        end
    end

    // Carry valid/id through the issue and capture stages; latch read data as it leaves the file
    always_comb begin
        i_stg_d.vld  = acc;
        i_stg_d.id   = win_id;
        c_stg_d      = i_stg_q;
        resp_valid_d = c_stg_q.vld;
        resp_id_d    = resp_id_q;
        resp_ad_d    = resp_ad_q;
        resp_bd_d    = resp_bd_q;
        if (c_stg_q.vld) begin
            resp_id_d = c_stg_q.id;
            resp_ad_d = RF_AD;
            resp_bd_d = RF_BD;
        end
    end

    // Pipeline registers; async reset discards anything in flight and drops RF_RW at once
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr_q        <= '0;
            rf_aa_q      <= '0;
            rf_ba_q      <= '0;
            rf_da_q      <= '0;
            rf_dd_q      <= '0;
            rf_rw_q      <= 1'b0;
            i_stg_q      <= '0;
            c_stg_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_ad_q    <= '0;
            resp_bd_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            rf_aa_q      <= rf_aa_d;
            rf_ba_q      <= rf_ba_d;
            rf_da_q      <= rf_da_d;
            rf_dd_q      <= rf_dd_d;
            rf_rw_q      <= rf_rw_d;
            i_stg_q      <= i_stg_d;
            c_stg_q      <= c_stg_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_ad_q    <= resp_ad_d;
            resp_bd_q    <= resp_bd_d;
        end
    end

    assign RF_AA      = rf_aa_q;
    assign RF_BA      = rf_ba_q;
    assign RF_DA      = rf_da_q;
    assign RF_DD      = rf_dd_q;
    assign RF_RW      = rf_rw_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_ad    = resp_ad_q;
    assign resp_bd    = resp_bd_q;
    assign busy       = i_stg_q.vld | c_stg_q.vld;

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Round-robin arbiter sharing one 8×16 register file among NREQ requesters. Each requester issues single operations: a two-operand read, a write, or both in one cycle. The arbiter registers the winning operation onto the register-file port and returns the read data to the winner with fixed latency. It sits between the datapath sequencers and the register file and is the only block that drives the file's address, data and write-strobe inputs.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 16: data width
- AW, 3: register address width (8 registers)
- LOCK_MAX, 4: maximum consecutive locked grants (only with RFARB_LOCK_EN)

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot grant; acceptance = valid & ready at CLK edge
- req_we  in  NREQ  write requested, one bit per requester
- req_aa, req_ba  in  NREQ*AW  read addresses A and B, packed, requester i at [i*AW +: AW]
- req_da  in  NREQ*AW  write address, packed
- req_dd  in  NREQ*DW  write data, packed
- req_lock  in  NREQ  keep grant for the next op (RFARB_LOCK_EN only)
- RF_AA, RF_BA, RF_DA  out  AW  register-file addresses, registered
- RF_DD  out  DW  register-file write data, registered
- RF_RW  out  1  register-file write strobe, registered
- RF_AD, RF_BD  in  DW  register-file read data, registered inside the file
- resp_valid  out  1  read response strobe, one cycle
- resp_id  out  3  index of the requester that owns the response
- resp_ad, resp_bd  out  DW  returned operands
- busy  out  1  an operation is in the issue or capture stage

## Operation
- Grant: combinational rotating priority starting at pointer `ptr`. `req_ready` is all zero when no `req_valid` is set and while RESET is low.
- On acceptance of requester i, the requester's fields are captured into the RF_* registers and `ptr` becomes (i+1) mod NREQ. `RF_RW` = `req_we[i]`.
- When no operation is accepted, `RF_RW` is 0. The address and data registers hold their previous values.
- Register-file contract: the file samples RF_* on CLK and presents AD/BD on the following cycle. Reads are read-before-write: a same-cycle read of the register being written returns the old value.
- A response is generated for every accepted operation, including writes. For a write-only operation, resp_ad and resp_bd carry the current contents at the issued AA and BA.
- There is no response backpressure; requesters must accept `resp_valid` unconditionally.
- Pipeline stages:
  - G: grant/accept.
  - I: RF_* valid, file samples.
  - C: arbiter captures RF_AD/BD into resp_* registers together with a delayed valid/id.
- Back-to-back operations from any mix of requesters issue every cycle, giving a throughput of 1 op per cycle.
- Reset values: all RF_* 0, RF_RW 0, resp_valid 0, resp_id 0, resp_ad/bd 0, busy 0, ptr 0, lock counter 0.
- Reset asserted mid-operation: in-flight operations are discarded, no response is issued, and RF_RW drops to 0 asynchronously.

## Timing
- Acceptance at edge T0 → RF_* valid in cycle T0..T1 → file updates at T1 → resp_* captured at T2 → resp_valid high in cycle T2..T3.
- Latency is 2 cycles from acceptance edge to response.
- Write at T0 followed by a read of the same register accepted at T1: the read returns the new value. No forwarding is needed.
- busy = stage-I valid OR stage-C valid.

## Configuration
- RFARB_LOCK_EN defined:
  - If an op from i is accepted with `req_lock[i]`=1, requester i keeps exclusive grant next cycle when `req_valid[i]`=1, regardless of ptr.
  - A lock counter counts consecutive locked grants. After LOCK_MAX of them the lock is ignored for one arbitration and ptr advances normally.
  - The lock releases immediately if `req_valid[i]`=0 or `req_lock[i]`=0.
- RFARB_LOCK_EN undefined: the `req_lock` port remains but is ignored, and there is no lock counter logic.

## Structure
- Package rfarb_pkg: default NREQ, DW, AW and LOCK_MAX, plus the stage-valid/id record type.
- Sub-module rr_grant: combinational rotating-priority one-hot grant from (valid vector, ptr).

## Test plan
- Reset, then requester 2 writes R5=16'hBEEF, then requester 0 reads AA=5, BA=0 → resp_id=0, resp_ad=16'hBEEF, resp_bd=16'h0000, 2 cycles after acceptance.
- All four requesters valid continuously → grants cycle 0,1,2,3,0…; each resp_id matches acceptance order; one response per cycle.
- Single op with we=1, DA=AA=3, DD=16'h1234, R3 previously 16'h0042 → resp_ad=16'h0042; a following read of R3 returns 16'h1234.
- RFARB_LOCK_EN: requester 1 holds lock with all others valid → exactly LOCK_MAX consecutive grants to 1, then a grant to 2.
- Reset pulsed low one cycle after acceptance → no resp_valid, RF_RW=0 immediately, and after release grant restarts at requester 0.
- No requests for 10 cycles → req_ready=0, RF_RW=0, busy=0 throughout.
